// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: framer state encoding, default baud
//               divisor, parity modes and a parity helper (TX and RX side).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 3-bit state encoding constants, reused by the RX framer
    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_FETCH  = 3'd1;
    localparam logic [2:0] C_ST_LOAD   = 3'd2;
    localparam logic [2:0] C_ST_START  = 3'd3;
    localparam logic [2:0] C_ST_DATA   = 3'd4;
    localparam logic [2:0] C_ST_PARITY = 3'd5;
    localparam logic [2:0] C_ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_FETCH  = C_ST_FETCH,
        ST_LOAD   = C_ST_LOAD,
        ST_START  = C_ST_START,
        ST_DATA   = C_ST_DATA,
        ST_PARITY = C_ST_PARITY,
        ST_STOP   = C_ST_STOP
    } uart_state_e;

    // 40 MHz system clock / 115200 baud
    localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd347;

    // Parity modes
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity is the XOR of the data bits; odd parity is its inverse
    function automatic logic calc_parity(input logic [7:0] data, input logic mode);
        return (^data) ^ mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : 16-bit bit-period divider. Counts 0..BAUD_DIV-1 and pulses
//               bit_tick_o on the last count of every bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam logic [15:0] c_last_count = BAUD_DIV - 16'd1;

    logic [15:0] r_count;
    logic        w_tick;

    assign w_tick     = (r_count == c_last_count);
    assign bit_tick_o = w_tick;

    // Divide counter: wraps at each bit boundary so bit periods never drift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 16'd0;
        end else if (clear_i || w_tick) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : UART transmit framer. Pops bytes from the TX FIFO and sends
//               start / 8 data (LSB first) / optional parity / stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        PARITY_ODD = 1'b0,
    parameter logic [1:0]  STOP_BITS  = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       n_fifo_re_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       byte_done_o
);

    // Index value of the final stop bit (bit index reused as stop counter)
    localparam logic [2:0] c_last_stop = 3'(STOP_BITS) - 3'd1;
    localparam logic       c_par_mode  = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic        r_parity;
    logic        w_parity_nxt;

    logic        w_bit_tick;
    logic        w_baud_clr;
    logic        w_tx;
    logic        w_n_re;
    logic        w_done;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (w_baud_clr),
        .bit_tick_o (w_bit_tick)
    );

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_parity  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_parity  <= w_parity_nxt;
        end
    end

    // Next-state and output decode; the baud counter is held clear until the
    // start bit so every frame begins on a fresh bit period
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_parity_nxt  = r_parity;
        w_tx          = 1'b1;
        w_n_re        = 1'b1;
        w_done        = 1'b0;
        w_baud_clr    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_clr = 1'b1;
                if (enable_i && !fifo_empty_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_baud_clr  = 1'b1;
                w_n_re      = 1'b0;
                w_state_nxt = ST_LOAD;
            end

            ST_LOAD: begin
                w_baud_clr    = 1'b1;
                w_shift_nxt   = fifo_data_i;
                w_parity_nxt  = calc_parity(fifo_data_i, c_par_mode);
                w_bit_idx_nxt = 3'd0;
                w_state_nxt   = ST_START;
            end

            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_tick) begin
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_DATA;
                end
            end

            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                w_tx = r_parity;
                if (w_bit_tick) begin
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_STOP;
                end
            end

            ST_STOP: begin
                w_tx = 1'b1;
                if (w_bit_tick) begin
                    if (r_bit_idx == c_last_stop) begin
                        w_done        = 1'b1;
                        w_bit_idx_nxt = 3'd0;
                        // FIFO state only matters here and in IDLE
                        if (enable_i && !fifo_empty_i) begin
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx_o        = w_tx;
    assign n_fifo_re_o = w_n_re;
    assign byte_done_o = w_done;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_framer
// Description : Scoreboard bench for uart_tx_framer across several parameter
//               sets, checking the TX line cycle by cycle against frames
//               built from the byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int NCFG = 5;
    localparam int C_BAUD [NCFG] = '{4, 4, 4, 4, 2};
    localparam int C_PEN  [NCFG] = '{0, 1, 1, 0, 1};
    localparam int C_PODD [NCFG] = '{0, 0, 1, 0, 1};
    localparam int C_STOP [NCFG] = '{1, 1, 1, 2, 2};

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [7:0]      fifo_data [NCFG];
    logic [NCFG-1:0] fifo_empty;
    logic [NCFG-1:0] nre;
    logic [NCFG-1:0] tx;
    logic [NCFG-1:0] busy;
    logic [NCFG-1:0] done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;

    logic [7:0] fifo_q  [NCFG][$];
    logic [7:0] exp_q   [NCFG][$];
    bit   [1:0] trace_q [NCFG][$];
    int         phase      [NCFG];
    int         dut_frames [NCFG];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : g_dut
            uart_tx_framer #(
                .BAUD_DIV   (16'(C_BAUD[g])),
                .PARITY_EN  (C_PEN[g] != 0),
                .PARITY_ODD (C_PODD[g] != 0),
                .STOP_BITS  (2'(C_STOP[g]))
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .enable_i     (enable),
                .fifo_data_i  (fifo_data[g]),
                .fifo_empty_i (fifo_empty[g]),
                .n_fifo_re_o  (nre[g]),
                .tx_o         (tx[g]),
                .busy_o       (busy[g]),
                .byte_done_o  (done[g])
            );
        end
    endgenerate

    // FIFO model: data appears the cycle after the read strobe, garbage otherwise
    initial begin
        logic [7:0] hold [NCFG];
        bit         pend [NCFG];
        for (int i = 0; i < NCFG; i++) begin
            fifo_empty[i] = 1'b1;
            fifo_data[i]  = 8'h00;
            pend[i]       = 1'b0;
            hold[i]       = 8'h00;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NCFG; i++) begin
                if (pend[i]) begin
                    fifo_data[i] = hold[i];
                    pend[i]      = 1'b0;
                end else begin
                    fifo_data[i] = 8'($urandom);
                end
                if (!nre[i] && fifo_q[i].size() > 0) begin
                    hold[i] = fifo_q[i].pop_front();
                    pend[i] = 1'b1;
                end
                fifo_empty[i] = (fifo_q[i].size() == 0);
            end
        end
    end

    // Monitor: pops the expected byte on each read strobe and expands it into
    // the expected per-clock line trace
    initial begin
        int cyc = 0;
        for (int i = 0; i < NCFG; i++) begin
            phase[i]      = 0;
            dut_frames[i] = 0;
        end
        forever begin
            @(posedge clk);
            #4;
            cyc++;
            for (int i = 0; i < NCFG; i++) begin
                logic [3:0] got;
                logic [3:0] expv;
                got = {tx[i], done[i], busy[i], nre[i]};
                if (rst && done[i]) dut_frames[i]++;
                if (!rst) begin
                    expv = 4'b1001;
                    phase[i] = 0;
                    trace_q[i].delete();
                end else if (phase[i] == 0) begin
                    expv = 4'b1001;
                    if (enable && !fifo_empty[i]) phase[i] = 1;
                end else if (phase[i] == 1) begin
                    expv = 4'b1010;
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL strobe cfg%0d cycle %0d: read with no byte queued, got 1 required 0", i, cyc);
                        phase[i] = 0;
                    end else begin
                        logic [7:0] d;
                        int nb;
                        d  = exp_q[i].pop_front();
                        nb = 1 + 8 + C_PEN[i] + C_STOP[i];
                        trace_q[i].push_back(2'b10);
                        for (int k = 0; k < nb; k++) begin
                            bit b;
                            if (k == 0)                     b = 1'b0;
                            else if (k <= 8)                b = d[k-1];
                            else if (k == 9 && C_PEN[i] != 0) b = (^d) ^ (C_PODD[i] != 0);
                            else                            b = 1'b1;
                            for (int c = 0; c < C_BAUD[i]; c++)
                                trace_q[i].push_back({b, (k == nb - 1) && (c == C_BAUD[i] - 1)});
                        end
                        phase[i] = 2;
                    end
                end else begin
                    bit [1:0] e;
                    e = trace_q[i].pop_front();
                    expv = {e[1], e[0], 2'b11};
                    if (trace_q[i].size() == 0)
                        phase[i] = (enable && !fifo_empty[i]) ? 1 : 0;
                end
                n_checks++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL line cfg%0d cycle %0d: got tx,done,busy,nre=%b required %b", i, cyc, got, expv);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        for (int i = 0; i < NCFG; i++) begin
            fifo_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
        n_pushed++;
    endtask

    task automatic wait_idle(input int limit, input bit need_empty);
        int k = 0;
        step(3);
        while (!(busy == '0 && (!need_empty || fifo_empty == '1)) && k < limit) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k >= limit) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b empty=%b required busy=0 after %0d clks", busy, fifo_empty, limit);
        end
    endtask

    // Stimulus
    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
        enable = 1'b1;

        push(8'h55);
        wait_idle(200, 1'b1);
        push(8'h07);
        wait_idle(200, 1'b1);

        // back-to-back frames
        push(8'hA5);
        push(8'h3C);
        wait_idle(300, 1'b1);

        // enable drops mid-frame with a byte still waiting
        push(8'hF0);
        push(8'h11);
        step(20);
        enable = 1'b0;
        wait_idle(200, 1'b0);
        step(20);
        enable = 1'b1;
        wait_idle(200, 1'b1);

        // reset in the middle of a data bit aborts 8'hC3
        push(8'hC3);
        push(8'h9A);
        step(15);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        wait_idle(300, 1'b1);

        // randomized traffic with enable toggling
        repeat (40) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) enable = 1'($urandom_range(0, 1));
            step($urandom_range(0, 60));
        end
        enable = 1'b1;
        wait_idle(20000, 1'b1);
        step(4);

        for (int i = 0; i < NCFG; i++) begin
            n_checks++;
            if (dut_frames[i] != n_pushed - 1) begin
                n_fail++;
                $display("FAIL frame_count cfg%0d: got %0d required %0d", i, dut_frames[i], n_pushed - 1);
            end
            n_checks++;
            if (exp_q[i].size() != 0 || phase[i] != 0) begin
                n_fail++;
                $display("FAIL drained cfg%0d: got %0d bytes pending required 0", i, exp_q[i].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial transmit stage directly downstream of the byte FIFO on the UART TX path. Pops one byte at a time through the FIFO's active-low read strobe and frames it as start/8 data (LSB first)/optional parity/stop bits. Drives the TX line at a parameterised baud rate. Reports busy and a per-byte completion pulse to the register/control block.

Parameters:
BAUD_DIV, 16'd347, clk cycles per bit (40 MHz / 115200); legal range 2..65535
PARITY_EN, 1'b0, 1 = insert parity bit after data bits
PARITY_ODD, 1'b0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 2'd1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, >= 40 MHz
rst  input  1  asynchronous active-low reset; release synchronous to clk
enable_i  input  1  1 = start new frames while FIFO non-empty; 0 = finish current frame then idle
fifo_data_i  input  8  FIFO data_o; valid the cycle after the read strobe
fifo_empty_i  input  1  FIFO p_empty_o
n_fifo_re_o  output  1  active-low FIFO read strobe; one clk per byte
tx_o  output  1  serial line; idle high
busy_o  output  1  1 in any state other than IDLE
byte_done_o  output  1  one-clk pulse at the end of the last stop bit

Behaviour:
- Reset (async, rst = 0): state = IDLE, tx_o = 1, n_fifo_re_o = 1, busy_o = 0, byte_done_o = 0, baud counter = 0, shift register = 8'h00. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if enable_i = 1 and fifo_empty_i = 0, go to FETCH next clk. Otherwise stay in IDLE.
- FETCH: n_fifo_re_o = 0 for exactly this one cycle. Go to LOAD.
- LOAD: capture fifo_data_i into the shift register, compute parity, clear the baud counter. Go to START.
- START: tx_o = 0 for BAUD_DIV clks. Go to DATA with bit index 0.
- DATA: tx_o = shift[0] for BAUD_DIV clks, then shift right and increment the index. After bit index 7, go to PARITY if PARITY_EN = 1, else STOP.
- Parity bit value:
  - even parity: XOR of the 8 data bits
  - odd parity: inverted XOR of the 8 data bits
- PARITY: tx_o = parity bit for BAUD_DIV clks. Go to STOP.
- STOP: tx_o = 1 for STOP_BITS × BAUD_DIV clks. byte_done_o pulses on the final clk of the stop period.
  - Next state FETCH if enable_i = 1 and fifo_empty_i = 0, else IDLE.
  - Back-to-back frames therefore have exactly 2 clks of idle-high (FETCH + LOAD) between stop end and start.
- tx_o = 1 in IDLE, FETCH and LOAD.
- Bit timing: the baud counter runs 0..BAUD_DIV-1 and wraps to 0 at each bit boundary. Every bit lasts exactly BAUD_DIV clks with no cumulative drift.
- Latency: from IDLE with data available, FETCH → LOAD → first start-bit clk is 2 clks.
- Frame length: 2 + (1 + 8 + PARITY_EN + STOP_BITS) × BAUD_DIV clks.
- enable_i falling mid-frame: the current frame completes normally, then the block goes to IDLE.
- fifo_empty_i is sampled only in IDLE and on the last STOP clk. The FIFO going empty mid-frame has no effect.
- Never assert n_fifo_re_o while fifo_empty_i = 1. No read occurs outside FETCH.
- Counters are 16-bit; the bit index is 3-bit. No arithmetic overflow is possible within the legal ranges.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (3-bit) for the states above
  - default BAUD_DIV
  - parity mode constants (PAR_EVEN, PAR_ODD)
  - these are reused by the RX side
- One sub-module: uart_baud_gen. It is a 16-bit divide counter with a synchronous clear and a bit_tick output pulsing on count = BAUD_DIV-1. The framer FSM stays in the top module.

Test Plan:
- BAUD_DIV = 4, no parity, 1 stop; FIFO holds 8'h55; enable_i = 1.
  - n_fifo_re_o low 1 clk
  - tx_o = 0,1,0,1,0,1,0,1,0,1, each held 4 clks (40 clks)
  - byte_done_o pulses once on the last stop clk
- BAUD_DIV = 4, PARITY_EN = 1, even parity, data 8'h07: parity bit = 1. Repeat with PARITY_ODD = 1: parity bit = 0. Frame length 2 + 11×4 = 46 clks.
- FIFO preloaded with 8'hA5, 8'h3C: two frames, exactly 2 idle-high clks between first stop end and second start; two read strobes total; then busy_o = 0 and IDLE.
- STOP_BITS = 2, BAUD_DIV = 4: stop high for 8 clks before byte_done_o pulses.
- enable_i deasserted during the DATA bit 3 of 8'hF0 with FIFO still non-empty: frame completes, no further read strobe, busy_o = 0.
- rst asserted during DATA: tx_o = 1, busy_o = 0, n_fifo_re_o = 1 immediately. After release with FIFO non-empty, a fresh FETCH occurs and the full frame is sent.
